// File: rtl/uart_instr_rx.sv
// UART instruction receiver: assembles INSTR_BYTES 8N1 frames into one instruction.
// Synchronised rx, mid-bit sampling, glitch/stop/timeout checks, valid/ready output.
module uart_instr_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int INSTR_BYTES  = 2,
    parameter int INSTR_WIDTH  = 15,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   frame_error,
    output logic                   timeout_error,
    output logic                   overrun,
    output logic                   busy
);

    localparam int PACK_W  = INSTR_BYTES * DATA_BITS;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int IDX_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int TMO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TMO_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [PACK_W-1:0]      pack_q, pack_d;
    logic [PACK_W-1:0]      packed_w;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [INSTR_WIDTH-1:0] out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   terr_q, terr_d;
    logic                   ovr_q, ovr_d;
    logic                   fall;

    assign fall = rx_prev_q & ~rx_sync_q;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            pack_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            pack_q  <= pack_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM, byte packing, handshake and error detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pack_d  = pack_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        out_d   = out_q;
        valid_d = valid_q & ~instr_ready;
        ferr_d  = 1'b0;
        terr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Packing register with the just-received byte dropped into its slot.
        packed_w = pack_q;
        for (int b = 0; b < INSTR_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                packed_w[b*DATA_BITS +: DATA_BITS] = shreg_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else if (idx_q != '0) begin
                    if (tmo_q == TMO_END) begin
                        terr_d = 1'b1;
                        idx_d  = '0;
                        pack_d = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_sync_q) begin
                        ferr_d = 1'b1;
                        idx_d  = '0;
                        pack_d = '0;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        pack_d = '0;
                        if (!valid_q || instr_ready) begin
                            out_d   = packed_w[INSTR_WIDTH-1:0];
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        pack_d = packed_w;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_out     = out_q;
    assign instr_valid   = valid_q;
    assign frame_error   = ferr_q;
    assign timeout_error = terr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != S_IDLE) || (idx_q != '0);

endmodule
